// File: rtl/ctrl_decode_stage.sv
// rtl/ctrl_decode_stage.sv - registered RV32I decode stage and ID/EX control pipeline register
module ctrl_decode_stage #(
  parameter int XLEN      = 32,
  parameter bit HAZARD_EN = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic [XLEN-1:0]  id_pc,
  input  logic             hold,
  input  logic             flush,
  output logic             stall_if,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [4:0]       ex_rd,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7b5,
  output logic [1:0]       ex_alu_op,
  output logic             ex_alu_src,
  output logic [1:0]       ex_alu_src_a,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_reg_write,
  output logic             ex_branch,
  output logic             ex_jump,
  output logic             ex_jump_reg,
  output logic [1:0]       ex_result_sel,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic [6:0] opcode;
  logic [4:0] id_rd;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;

  logic [1:0] d_alu_op;
  logic       d_alu_src;
  logic [1:0] d_alu_src_a;
  logic       d_mem_read;
  logic       d_mem_write;
  logic       d_reg_write;
  logic       d_branch;
  logic       d_jump;
  logic       d_jump_reg;
  logic [1:0] d_result_sel;
  logic       d_illegal;
  logic       rs1_used;
  logic       rs2_used;

  logic       rs_match;
  logic       load_instr;
  logic       update_en;

  assign opcode = id_instr[6:0];
  assign id_rd  = id_instr[11:7];
  assign id_rs1 = id_instr[19:15];
  assign id_rs2 = id_instr[24:20];

  // Opcode to control bundle; unsupported opcodes leave every control at 0.
  always_comb begin
    d_alu_op     = 2'b00;
    d_alu_src    = 1'b0;
    d_alu_src_a  = 2'b00;
    d_mem_read   = 1'b0;
    d_mem_write  = 1'b0;
    d_reg_write  = 1'b0;
    d_branch     = 1'b0;
    d_jump       = 1'b0;
    d_jump_reg   = 1'b0;
    d_result_sel = 2'b00;
    d_illegal    = 1'b0;
    rs1_used     = 1'b0;
    rs2_used     = 1'b0;
    case (opcode)
      OP_R: begin
        d_alu_op    = 2'b10;
        d_reg_write = 1'b1;
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
      end
      OP_I: begin
        d_alu_op    = 2'b11;
        d_alu_src   = 1'b1;
        d_reg_write = 1'b1;
        rs1_used    = 1'b1;
      end
      OP_LOAD: begin
        d_alu_src    = 1'b1;
        d_mem_read   = 1'b1;
        d_reg_write  = 1'b1;
        d_result_sel = 2'b01;
        rs1_used     = 1'b1;
      end
      OP_STORE: begin
        d_alu_src   = 1'b1;
        d_mem_write = 1'b1;
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
      end
      OP_BR: begin
        d_alu_op = 2'b01;
        d_branch = 1'b1;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OP_JAL: begin
        d_jump       = 1'b1;
        d_reg_write  = 1'b1;
        d_result_sel = 2'b10;
        d_alu_src_a  = 2'b01;
        d_alu_src    = 1'b1;
      end
      OP_JALR: begin
        d_jump       = 1'b1;
        d_jump_reg   = 1'b1;
        d_reg_write  = 1'b1;
        d_result_sel = 2'b10;
        d_alu_src    = 1'b1;
        rs1_used     = 1'b1;
      end
      OP_LUI: begin
        d_alu_src_a = 2'b10;
        d_alu_src   = 1'b1;
        d_reg_write = 1'b1;
      end
      OP_AUIPC: begin
        d_alu_src_a = 2'b01;
        d_alu_src   = 1'b1;
        d_reg_write = 1'b1;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  // Load-use: the load in EX writes a register the ID instruction actually reads.
  always_comb begin
    rs_match = (rs1_used && (ex_rd == id_rs1)) || (rs2_used && (ex_rd == id_rs2));
    stall_if = HAZARD_EN && id_valid && !flush && ex_valid && ex_mem_read
               && (ex_rd != 5'd0) && rs_match;
  end

  // Flush forces a bubble even under hold; otherwise hold freezes everything.
  assign update_en  = flush || !hold;
  assign load_instr = !flush && id_valid && !stall_if;

  // ID/EX control register: decoded bundle on a real issue, all-zero bubble otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_rd         <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_funct3     <= '0;
      ex_funct7b5   <= 1'b0;
      ex_alu_op     <= '0;
      ex_alu_src    <= 1'b0;
      ex_alu_src_a  <= '0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_branch     <= 1'b0;
      ex_jump       <= 1'b0;
      ex_jump_reg   <= 1'b0;
      ex_result_sel <= '0;
      ex_illegal    <= 1'b0;
    end else if (update_en) begin
      ex_valid      <= load_instr;
      ex_pc         <= load_instr ? id_pc : '0;
      ex_rd         <= load_instr ? id_rd : 5'd0;
      ex_rs1        <= load_instr ? id_rs1 : 5'd0;
      ex_rs2        <= load_instr ? id_rs2 : 5'd0;
      ex_funct3     <= load_instr ? id_instr[14:12] : 3'd0;
      ex_funct7b5   <= load_instr && id_instr[30];
      ex_alu_op     <= load_instr ? d_alu_op : 2'b00;
      ex_alu_src    <= load_instr && d_alu_src;
      ex_alu_src_a  <= load_instr ? d_alu_src_a : 2'b00;
      ex_mem_read   <= load_instr && d_mem_read;
      ex_mem_write  <= load_instr && d_mem_write;
      ex_reg_write  <= load_instr && d_reg_write;
      ex_branch     <= load_instr && d_branch;
      ex_jump       <= load_instr && d_jump;
      ex_jump_reg   <= load_instr && d_jump_reg;
      ex_result_sel <= load_instr ? d_result_sel : 2'b00;
      ex_illegal    <= load_instr && d_illegal;
    end
  end

  // Saturating count of illegal instructions that actually issued into EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_cnt <= '0;
    end else if (update_en && load_instr && d_illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// tb/tb_ctrl_decode_stage.sv - scoreboard bench for ctrl_decode_stage (hazard on/off instances)
module tb_ctrl_decode_stage;

  localparam int XLEN = 32;
  localparam int CW   = 2;

  logic clk = 1'b0;
  logic rst;
  logic id_valid;
  logic [31:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic hold;
  logic flush;

  logic            stall_if      [2];
  logic            ex_valid      [2];
  logic [XLEN-1:0] ex_pc         [2];
  logic [4:0]      ex_rd         [2];
  logic [4:0]      ex_rs1        [2];
  logic [4:0]      ex_rs2        [2];
  logic [2:0]      ex_funct3     [2];
  logic            ex_funct7b5   [2];
  logic [1:0]      ex_alu_op     [2];
  logic            ex_alu_src    [2];
  logic [1:0]      ex_alu_src_a  [2];
  logic            ex_mem_read   [2];
  logic            ex_mem_write  [2];
  logic            ex_reg_write  [2];
  logic            ex_branch     [2];
  logic            ex_jump       [2];
  logic            ex_jump_reg   [2];
  logic [1:0]      ex_result_sel [2];
  logic            ex_illegal    [2];
  logic [CW-1:0]   illegal_cnt   [2];

  always #5 clk = ~clk;

  // Instance 0 has hazard detection on, instance 1 has it off; both see the same stimulus.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    ctrl_decode_stage #(.XLEN(XLEN), .HAZARD_EN(g == 0), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
      .hold(hold), .flush(flush), .stall_if(stall_if[g]), .ex_valid(ex_valid[g]),
      .ex_pc(ex_pc[g]), .ex_rd(ex_rd[g]), .ex_rs1(ex_rs1[g]), .ex_rs2(ex_rs2[g]),
      .ex_funct3(ex_funct3[g]), .ex_funct7b5(ex_funct7b5[g]), .ex_alu_op(ex_alu_op[g]),
      .ex_alu_src(ex_alu_src[g]), .ex_alu_src_a(ex_alu_src_a[g]),
      .ex_mem_read(ex_mem_read[g]), .ex_mem_write(ex_mem_write[g]),
      .ex_reg_write(ex_reg_write[g]), .ex_branch(ex_branch[g]), .ex_jump(ex_jump[g]),
      .ex_jump_reg(ex_jump_reg[g]), .ex_result_sel(ex_result_sel[g]),
      .ex_illegal(ex_illegal[g]), .illegal_cnt(illegal_cnt[g])
    );
  end

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic [1:0]  src_a;
    logic        mr;
    logic        mw;
    logic        rw;
    logic        br;
    logic        j;
    logic        jr;
    logic [1:0]  rsel;
    logic        ill;
  } ex_t;

  typedef struct packed {
    ex_t [1:0]           bun;
    logic [1:0]          stall;
    logic [1:0][CW-1:0]  cnt;
  } rec_t;

  ex_t         m  [2];
  logic [CW-1:0] mc [2];
  rec_t        q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ex_t actual(input int i);
    ex_t a;
    a = '{ex_valid[i], ex_pc[i], ex_rd[i], ex_rs1[i], ex_rs2[i], ex_funct3[i], ex_funct7b5[i],
          ex_alu_op[i], ex_alu_src[i], ex_alu_src_a[i], ex_mem_read[i], ex_mem_write[i],
          ex_reg_write[i], ex_branch[i], ex_jump[i], ex_jump_reg[i], ex_result_sel[i],
          ex_illegal[i]};
    return a;
  endfunction

  // Reference decode: each control is a set-membership test over the instruction classes.
  function automatic ex_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    ex_t e;
    logic [6:0] op;
    logic r, ia, ld, st, br, jal, jalr, lui, aui, legal;
    op = ins[6:0];
    r = (op == 7'b0110011); ia = (op == 7'b0010011); ld = (op == 7'b0000011);
    st = (op == 7'b0100011); br = (op == 7'b1100011); jal = (op == 7'b1101111);
    jalr = (op == 7'b1100111); lui = (op == 7'b0110111); aui = (op == 7'b0010111);
    legal = r | ia | ld | st | br | jal | jalr | lui | aui;
    e = '0;
    e.valid   = 1'b1;
    e.pc      = pc;
    e.rd      = ins[11:7];
    e.rs1     = ins[19:15];
    e.rs2     = ins[24:20];
    e.f3      = ins[14:12];
    e.f7b5    = ins[30];
    e.alu_op  = r ? 2'd2 : ia ? 2'd3 : br ? 2'd1 : 2'd0;
    e.alu_src = ia | ld | st | jal | jalr | lui | aui;
    e.src_a   = (jal | aui) ? 2'd1 : lui ? 2'd2 : 2'd0;
    e.mr      = ld;
    e.mw      = st;
    e.rw      = r | ia | ld | jal | jalr | lui | aui;
    e.br      = br;
    e.j       = jal | jalr;
    e.jr      = jalr;
    e.rsel    = ld ? 2'd1 : (jal | jalr) ? 2'd2 : 2'd0;
    e.ill     = !legal;
    return e;
  endfunction

  function automatic logic ref_stall(input int i, input logic v, input logic [31:0] ins, input logic f);
    logic [6:0] op;
    logic u1, u2;
    op = ins[6:0];
    u1 = op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
    u2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    return (i == 0) && v && !f && m[i].valid && m[i].mr && (m[i].rd != 5'd0)
           && ((u1 && m[i].rd == ins[19:15]) || (u2 && m[i].rd == ins[24:20]));
  endfunction

  // Present one ID cycle, queue the expectation for the monitor, then advance the models.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic h, input logic f);
    rec_t r;
    logic st [2];
    id_valid = v; id_instr = ins; id_pc = pc; hold = h; flush = f;
    for (int i = 0; i < 2; i++) begin
      st[i]      = ref_stall(i, v, ins, f);
      r.bun[i]   = m[i];
      r.stall[i] = st[i];
      r.cnt[i]   = mc[i];
    end
    q.push_back(r);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (f) m[i] = '0;
      else if (h) m[i] = m[i];
      else if (st[i] || !v) m[i] = '0;
      else begin
        m[i] = ref_decode(ins, pc);
        if (m[i].ill && mc[i] != CW'(3)) mc[i] = mc[i] + CW'(1);
      end
    end
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [2:0] f3);
    return {7'b0000000, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [6:0] pick_op(input int k);
    case (k)
      0: return 7'b0110011;
      1: return 7'b0010011;
      2: return 7'b0000011;
      3: return 7'b0100011;
      4: return 7'b1100011;
      5: return 7'b1101111;
      6: return 7'b1100111;
      7: return 7'b0110111;
      8: return 7'b0010111;
      9: return 7'b1111111;
      default: return 7'($urandom);
    endcase
  endfunction

  // Monitor: compare the queued expectation against both instances on every falling edge.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        r = q.pop_front();
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("ex_bundle[%0d]", i), 128'(actual(i)), 128'(r.bun[i]));
          chk($sformatf("stall_if[%0d]", i), 128'(stall_if[i]), 128'(r.stall[i]));
          chk($sformatf("illegal_cnt[%0d]", i), 128'(illegal_cnt[i]), 128'(r.cnt[i]));
        end
      end
    end
  end

  initial begin
    logic [31:0] ins;
    logic [31:0] pc;
    rst = 1'b1; id_valid = 1'b0; id_instr = '0; id_pc = '0; hold = 1'b0; flush = 1'b0;
    for (int i = 0; i < 2; i++) begin m[i] = '0; mc[i] = '0; end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Decode sweep over the nine legal opcodes.
    pc = 32'h100;
    for (int k = 0; k < 9; k++) begin
      ins = $urandom;
      ins[6:0] = pick_op(k);
      step(1'b1, ins, pc, 1'b0, 1'b0);
      pc += 4;
    end
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Illegal opcode five times: counter saturates at 3.
    for (int k = 0; k < 5; k++) step(1'b1, mk(7'b1111111, 5'd7, 5'd1, 5'd2, 3'd0), 32'h200 + 4 * k, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Load-use: lw x5,0(x1); add x6,x5,x2 (presented twice: re-presented after the stall).
    step(1'b1, mk(7'b0000011, 5'd5, 5'd1, 5'd0, 3'd2), 32'h300, 1'b0, 1'b0);
    step(1'b1, mk(7'b0110011, 5'd6, 5'd5, 5'd2, 3'd0), 32'h304, 1'b0, 1'b0);
    step(1'b1, mk(7'b0110011, 5'd6, 5'd5, 5'd2, 3'd0), 32'h304, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    // Same pair with rd = x0: no stall.
    step(1'b1, mk(7'b0000011, 5'd0, 5'd1, 5'd0, 3'd2), 32'h310, 1'b0, 1'b0);
    step(1'b1, mk(7'b0110011, 5'd6, 5'd0, 5'd2, 3'd0), 32'h314, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Hold for three cycles with a new instruction in ID, then flush+hold together.
    step(1'b1, mk(7'b0000011, 5'd1, 5'd2, 5'd0, 3'd2), 32'h400, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, mk(7'b0110011, 5'd3, 5'd1, 5'd1, 3'd0), 32'h404, 1'b1, 1'b0);
    step(1'b1, mk(7'b0110011, 5'd3, 5'd1, 5'd1, 3'd0), 32'h404, 1'b1, 1'b1);
    // Flush while a hazard would otherwise stall.
    step(1'b1, mk(7'b0000011, 5'd4, 5'd2, 5'd0, 3'd2), 32'h410, 1'b0, 1'b0);
    step(1'b1, mk(7'b0110011, 5'd5, 5'd4, 5'd4, 3'd0), 32'h414, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle while EX holds a load.
    step(1'b1, mk(7'b0000011, 5'd3, 5'd1, 5'd0, 3'd2), 32'h500, 1'b0, 1'b0);
    id_valid = 1'b0; id_instr = '0;
    #1 rst = 1'b1;
    #1;
    chk("async_ex_valid", 128'(ex_valid[0]), 128'(0));
    chk("async_ex_mem_read", 128'(ex_mem_read[0]), 128'(0));
    chk("async_illegal_cnt", 128'(illegal_cnt[0]), 128'(0));
    chk("async_stall_if", 128'(stall_if[0]), 128'(0));
    for (int i = 0; i < 2; i++) begin m[i] = '0; mc[i] = '0; end
    @(posedge clk);
    #1 rst = 1'b0;

    // Randomized traffic with a small register range to provoke hazards.
    pc = 32'h1000;
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      ins[6:0]   = pick_op($urandom_range(0, 10));
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      step($urandom_range(0, 7) != 0, ins, pc, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      pc += 4;
    end
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
